cmb_obs_seq: RTL

Parametrised observation sequencer for the CMB controller. It generalises the fixed single-channel observation/rotation control to N RF-switch channels, a configurable number of steps per revolution and a burst of ADC triggers per channel. It can run a single revolution or continuous revolutions. It sits between the debounced push-button pulses (`init`, `trg`) and the stepper, RF-switch and ADC trigger pins, and supplies `rot_count` to the 7-segment angle display.

---
 rtl/cmb_pkg.sv | 44 ++++
 rtl/cmb_obs_seq_if.sv | 32 +++
 rtl/next_ch_sel.sv | 30 +++
 rtl/cmb_obs_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/cmb_pkg.sv
// Shared definitions for the CMB observation sequencer: state encoding,
// default timing constants and width helpers.
package cmb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_ACQ,
        ST_STEP,
        ST_DONE
    } state_e;

    // Defaults sized for the 50 MHz board clock.
    localparam int DEF_N_CH          = 4;
    localparam int DEF_STEPS_PER_REV = 400;
    localparam int DEF_ADC_PER_CH    = 4;
    localparam int DEF_SETTLE_CYC    = 50;
    localparam int DEF_ADC_GAP       = 1000;
    localparam int DEF_STEP_HI       = 250000;
    localparam int DEF_STEP_LO       = 250000;

    function automatic int cnt_w(input int steps);
        return $clog2(steps);
    endfunction

    // Index width that stays legal (>=1 bit) for a single-entry range.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int ph_w(input int settle, input int acq, input int hi, input int lo);
        return $clog2(max4(settle, acq, hi, lo) + 1);
    endfunction

endpackage

// File: rtl/cmb_obs_seq_if.sv
// Control/status bundle between the push-button front end and the
// observation sequencer driving stepper, RF switch and ADC trigger pins.
interface cmb_obs_seq_if
    import cmb_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int STEPS_PER_REV = DEF_STEPS_PER_REV
);
    localparam int CNT_W = cnt_w(STEPS_PER_REV);

    logic             init;
    logic             trg;
    logic             cont;
    logic [N_CH-1:0]  ch_mask;
    logic             rot_clk;
    logic [N_CH-1:0]  rf_sw;
    logic             adc_trg;
    logic             busy;
    logic             done;
    logic [CNT_W-1:0] rot_count;

    modport master (
        output init, trg, cont, ch_mask,
        input  rot_clk, rf_sw, adc_trg, busy, done, rot_count
    );

    modport slave (
        input  init, trg, cont, ch_mask,
        output rot_clk, rf_sw, adc_trg, busy, done, rot_count
    );

endinterface

// File: rtl/next_ch_sel.sv
// Combinational channel picker: next higher enabled channel after cur_idx_i,
// or the lowest enabled channel when from_start_i is set.
module next_ch_sel
    import cmb_pkg::*;
#(
    parameter int N_CH  = DEF_N_CH,
    parameter int IDX_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  mask_i,
    input  logic [IDX_W-1:0] cur_idx_i,
    input  logic             from_start_i,
    output logic [IDX_W-1:0] nxt_idx_o,
    output logic             none_o
);

    // NOTE: every output gets a default before the loop so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        nxt_idx_o = '0;
        none_o    = 1'b1;
        // Scanning downwards lets the lowest qualifying index win.
        for (int i = N_CH - 1; i >= 0; i--) begin
            if (mask_i[i] && (from_start_i || (IDX_W'(i) > cur_idx_i))) begin
                nxt_idx_o = IDX_W'(i);
                none_o    = 1'b0;
            end
        end
    end

endmodule

// File: rtl/cmb_obs_seq.sv
// Observation sequencer: per angle position, settle and burst-sample every
// enabled RF channel, then issue one stepper pulse; single or continuous revs.
module cmb_obs_seq
    import cmb_pkg::*;
#(
    parameter int N_CH          = DEF_N_CH,
    parameter int STEPS_PER_REV = DEF_STEPS_PER_REV,
    parameter int ADC_PER_CH    = DEF_ADC_PER_CH,
    parameter int SETTLE_CYC    = DEF_SETTLE_CYC,
    parameter int ADC_GAP       = DEF_ADC_GAP,
    parameter int STEP_HI       = DEF_STEP_HI,
    parameter int STEP_LO       = DEF_STEP_LO
) (
    input logic          clk50,
    input logic          rst_n,
    cmb_obs_seq_if.slave bus
);

    localparam int CNT_W = cnt_w(STEPS_PER_REV);
    localparam int IDX_W = idx_w(N_CH);
    localparam int AI_W  = idx_w(ADC_PER_CH);
    localparam int PH_W  = ph_w(SETTLE_CYC, ADC_PER_CH * ADC_GAP, STEP_HI, STEP_LO);

    state_e           state_q,     state_d;
    logic [PH_W-1:0]  phase_q,     phase_d;
    logic [AI_W-1:0]  adc_idx_q,   adc_idx_d;
    logic [IDX_W-1:0] ch_idx_q,    ch_idx_d;
    logic [N_CH-1:0]  mask_q,      mask_d;
    logic [CNT_W-1:0] rot_count_q, rot_count_d;
    logic             rot_clk_q,   rot_clk_d;
    logic             adc_trg_q,   adc_trg_d;
    logic             busy_q,      busy_d;
    logic             done_q,      done_d;
    logic [N_CH-1:0]  rf_sw_q,     rf_sw_d;

    logic             step_hi_d;
    logic             advance;
    logic [N_CH-1:0]  sel_mask;
    logic             sel_from_start;
    logic [IDX_W-1:0] sel_idx;
    logic             sel_none;

    // In IDLE the mask is not latched yet, so the selector looks at the live input.
    assign sel_mask       = (state_q == ST_IDLE) ? bus.ch_mask : mask_q;
    assign sel_from_start = (state_q != ST_ACQ);

    next_ch_sel #(
        .N_CH  (N_CH),
        .IDX_W (IDX_W)
    ) u_next_ch_sel (
        .mask_i       (sel_mask),
        .cur_idx_i    (ch_idx_q),
        .from_start_i (sel_from_start),
        .nxt_idx_o    (sel_idx),
        .none_o       (sel_none)
    );

    always_comb begin
        state_d     = state_q;
        phase_d     = phase_q;
        adc_idx_d   = adc_idx_q;
        ch_idx_d    = ch_idx_q;
        mask_d      = mask_q;
        rot_count_d = rot_count_q;
        step_hi_d   = rot_clk_q;
        advance     = 1'b0;

        if (bus.init) begin
            state_d     = ST_IDLE;
            phase_d     = '0;
            adc_idx_d   = '0;
            ch_idx_d    = '0;
            mask_d      = '0;
            rot_count_d = '0;
            step_hi_d   = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.trg) begin
                        mask_d  = bus.ch_mask;
                        advance = 1'b1;
                    end
                end

                ST_SETTLE: begin
                    if (phase_q == PH_W'(SETTLE_CYC - 1)) begin
                        state_d   = ST_ACQ;
                        phase_d   = '0;
                        adc_idx_d = '0;
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end

                // The phase counter times one ADC gap; adc_idx counts gaps in the burst.
                ST_ACQ: begin
                    if (phase_q == PH_W'(ADC_GAP - 1)) begin
                        phase_d = '0;
                        if (adc_idx_q == AI_W'(ADC_PER_CH - 1)) begin
                            advance = 1'b1;
                        end else begin
                            adc_idx_d = adc_idx_q + AI_W'(1);
                        end
                    end else begin
                        phase_d = phase_q + PH_W'(1);
                    end
                end

                ST_STEP: begin
                    if (rot_clk_q) begin
                        if (phase_q == PH_W'(STEP_HI - 1)) begin
                            phase_d     = '0;
                            step_hi_d   = 1'b0;
                            rot_count_d = (rot_count_q == CNT_W'(STEPS_PER_REV - 1))
                                        ? '0 : rot_count_q + CNT_W'(1);
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end else begin
                        if (phase_q == PH_W'(STEP_LO - 1)) begin
                            if ((rot_count_q == '0) && !bus.cont) begin
                                state_d = ST_DONE;
                                phase_d = '0;
                            end else begin
                                advance = 1'b1;
                            end
                        end else begin
                            phase_d = phase_q + PH_W'(1);
                        end
                    end
                end

                ST_DONE: begin
                    state_d = ST_IDLE;
                end

                default: begin
                    state_d = ST_IDLE;
                end
            endcase

            // Start of a channel (or a bare step when no channel remains).
            if (advance) begin
                phase_d = '0;
                if (sel_none) begin
                    state_d   = ST_STEP;
                    step_hi_d = 1'b1;
                end else begin
                    state_d  = ST_SETTLE;
                    ch_idx_d = sel_idx;
                end
            end
        end

        // Outputs are decoded from the next state and registered below.
        rot_clk_d = (state_d == ST_STEP) && step_hi_d;
        adc_trg_d = !((state_d == ST_ACQ) && (phase_d == '0));
        rf_sw_d   = ((state_d == ST_SETTLE) || (state_d == ST_ACQ))
                  ? (N_CH'(1) << ch_idx_d) : '0;
        busy_d    = (state_d == ST_SETTLE) || (state_d == ST_ACQ) || (state_d == ST_STEP);
        done_d    = (state_d == ST_DONE);
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples its pre-edge value regardless of statement order.
    always_ff @(posedge clk50 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            phase_q     <= '0;
            adc_idx_q   <= '0;
            ch_idx_q    <= '0;
            mask_q      <= '0;
            rot_count_q <= '0;
            rot_clk_q   <= 1'b0;
            adc_trg_q   <= 1'b1;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rf_sw_q     <= '0;
        end else begin
            state_q     <= state_d;
            phase_q     <= phase_d;
            adc_idx_q   <= adc_idx_d;
            ch_idx_q    <= ch_idx_d;
            mask_q      <= mask_d;
            rot_count_q <= rot_count_d;
            rot_clk_q   <= rot_clk_d;
            adc_trg_q   <= adc_trg_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rf_sw_q     <= rf_sw_d;
        end
    end

    assign bus.rot_clk   = rot_clk_q;
    assign bus.adc_trg   = adc_trg_q;
    assign bus.rf_sw     = rf_sw_q;
    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.rot_count = rot_count_q;

endmodule
